serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be legal for any value >= 1.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepted start edge.
REQ-007 diff  output  WIDTH  result (a - b) mod 2^WIDTH.
REQ-008 borrow  output  1  final borrow; 1 iff a < b, unsigned compare.
REQ-009 busy  output  1  high while an operation is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse marking diff and borrow valid.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 IDLE with start=1 at an edge: latch a and b, clear the bit index and the running borrow to 0, go to RUN.
REQ-013 IDLE with start=0: stay in IDLE; diff and borrow hold their last values.
REQ-014 RUN: each cycle process exactly one bit, LSB first, through one full-subtractor cell.
REQ-015 Full-subtractor cell inputs: operand bits a[i], b[i] and the running borrow; d[i] is written into diff bit i, and bout becomes the new running borrow.
REQ-016 RUN SHALL last exactly WIDTH cycles; after processing bit WIDTH-1, go to DONE and load borrow from the final bout.
REQ-017 DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: with start accepted at edge E0, done is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after E0.
REQ-019 busy=1 exactly in RUN; busy=0 in IDLE and DONE.
REQ-020 start asserted in RUN or DONE SHALL be ignored, with no queuing; a new request is accepted only in IDLE.
REQ-021 Changes on a or b after the accepted start SHALL NOT affect the in-flight result.
REQ-022 diff and borrow SHALL be valid from the done cycle and held stable until the next accepted start.
REQ-023 diff bits SHALL update progressively during RUN; consumers use them only when done=1 or afterwards.
REQ-024 Bit index width: clog2(WIDTH), minimum 1; it SHALL NOT wrap within one operation.
REQ-025 Back-to-back operation: start held high continuously SHALL give one operation per WIDTH+2 cycles.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, diff=0, borrow=0, bit index=0 and running borrow=0.
REQ-027 rst SHALL take priority over start and over any state, including mid-RUN; an aborted operation produces no done pulse.
REQ-028 The first start accepted after reset release starts a fresh operation with no residue from the aborted one.

Structure
REQ-029 State encoding constants (IDLE, RUN, DONE) SHALL live in a shared package, pkg_sub_defs, for reuse by other subtractor controllers.
REQ-030 The one-bit cell SHALL be a separate combinational sub-module, fullsub_bit:
  - d = x ^ y ^ bin
  - bout = (~x & y) | (~(x ^ y) & bin)
REQ-031 serial_sub_ctrl SHALL instantiate fullsub_bit exactly once; no WIDTH-wide combinational subtractor is permitted.

Verification
REQ-032 WIDTH=8, a=10, b=3, pulse start -> done at E0+9, diff=8'h07, borrow=0, busy high for 8 cycles.
REQ-033 a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1; a=8'h5A, b=8'h5A -> diff=8'h00, borrow=0.
REQ-034 start re-pulsed at E0+3 with a=1, b=1 -> ignored; result is that of the original operands, and only one done pulse occurs.
REQ-035 rst asserted at E0+4 of a run -> next cycle all outputs 0, state IDLE; no done pulse; subsequent a=200, b=55 -> diff=145, borrow=0.
REQ-036 WIDTH=1, all four input combinations (a,b) -> (diff,borrow) = 00→(0,0), 01→(1,1), 10→(1,0), 11→(0,0); done at E0+2 each time.
REQ-037 Randomised self-check (1000 operands, WIDTH=8) against a - b, with start held high -> one done every 10 cycles.

Source files
------------

// File: rtl/pkg_sub_defs.sv
// rtl/pkg_sub_defs.sv - shared state encoding and sizing helper for subtractor controllers
package pkg_sub_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_t;

    // Bit-index width: clog2 of the operand width, never narrower than one bit
    function automatic int idx_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fullsub_bit.sv
// rtl/fullsub_bit.sv - one-bit full-subtractor cell
module fullsub_bit (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_x ^ i_y ^ i_bin;
    assign o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial unsigned subtractor, one bit per cycle LSB first
module serial_sub_ctrl
    import pkg_sub_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int               IW       = idx_bits(WIDTH);
    localparam logic [IW-1:0]    LAST_IDX = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    sub_state_t       r_state;
    sub_state_t       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [IW-1:0]    r_idx;
    logic             r_bin;
    logic             r_borrow;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic             w_d;
    logic             w_bout;
    logic             w_last;

    // Shift-then-pick avoids index-width mismatches when WIDTH is 1
    assign w_a_sh = r_a >> r_idx;
    assign w_b_sh = r_b >> r_idx;
    assign w_last = (r_idx == LAST_IDX);

    fullsub_bit u_cell (
        .i_x    (w_a_sh[0]),
        .i_y    (w_b_sh[0]),
        .i_bin  (r_bin),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= '0;
                        r_bin <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_diff <= (r_diff & ~(ONE << r_idx)) | (WIDTH'(w_d) << r_idx);
                    r_bin  <= w_bout;
                    if (w_last) begin
                        r_borrow <= w_bout;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8, diff8;
    logic       a1, b1, diff1;
    logic       borrow8, busy8, done8;
    logic       borrow1, busy1, done1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .diff(diff8), .borrow(borrow8), .busy(busy8), .done(done8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .diff(diff1), .borrow(borrow1), .busy(busy1), .done(done1)
    );

    // Reference: modular difference and unsigned compare
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        d = 8'((int'(x) - int'(y) + 256) % 256);
        return {(x < y), d};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'h0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b diff=%h borrow=%b, required all 0", busy8, done8, diff8, borrow8);
        end
        checks++;
        if ({busy1, done1, diff1, borrow1} !== 4'h0) begin
            errors++;
            $display("FAIL reset1: busy=%b done=%b diff=%b borrow=%b, required all 0", busy1, done1, diff1, borrow1);
        end
        rst = 1'b0;
    endtask

    // One 8-bit operation; optional re-pulse of start mid-run with other operands
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input int repulse_at, input string name);
        int         first_done = -1;
        int         ndone = 0;
        int         nbusy = 0;
        logic [8:0] exp;
        logic [8:0] at_done = 9'h0;
        exp = ref8(av, bv);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = av; b8 = bv;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (busy8) nbusy++;
            if (done8) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = k;
                    at_done = {borrow8, diff8};
                end
            end
            if (k == repulse_at) begin start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; end
            if (k == repulse_at + 1) start8 = 1'b0;
        end
        checks++;
        if (first_done != 9 || ndone != 1) begin
            errors++;
            $display("FAIL %s latency: done at cycle %0d count %0d, required cycle 9 count 1", name, first_done, ndone);
        end
        checks++;
        if (nbusy != 8) begin
            errors++;
            $display("FAIL %s busy: %0d cycles, required 8", name, nbusy);
        end
        checks++;
        if (at_done !== exp) begin
            errors++;
            $display("FAIL %s result: borrow/diff=%b/%h, required %b/%h", name, at_done[8], at_done[7:0], exp[8], exp[7:0]);
        end
        checks++;
        if ({borrow8, diff8} !== exp) begin
            errors++;
            $display("FAIL %s hold: borrow/diff=%b/%h, required %b/%h", name, borrow8, diff8, exp[8], exp[7:0]);
        end
    endtask

    task automatic test_basic();
        run_op8(8'd10, 8'd3, 0, "a10_b3");
        run_op8(8'h00, 8'h01, 0, "a00_b01");
        run_op8(8'h5A, 8'h5A, 0, "a5a_b5a");
        run_op8(8'hFF, 8'h00, 0, "aff_b00");
    endtask

    task automatic test_ignore_start();
        run_op8(8'h37, 8'hC4, 3, "repulse");
    endtask

    task automatic test_reset_mid_run();
        int ndone = 0;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'h0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b diff=%h borrow=%b, required all 0", busy8, done8, diff8, borrow8);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL mid_reset_done: %0d done/busy cycles after abort, required 0", ndone);
        end
        run_op8(8'd200, 8'd55, 0, "after_reset");
    endtask

    task automatic test_width1();
        for (int i = 0; i < 4; i++) begin
            logic av, bv, ed, eb;
            int   first_done = -1;
            int   ndone = 0;
            logic [1:0] at_done = 2'b00;
            av = 1'(i >> 1); bv = 1'(i);
            ed = av ^ bv; eb = (av < bv);
            @(posedge clk); #1;
            start1 = 1'b1; a1 = av; b1 = bv;
            @(posedge clk); #1;
            start1 = 1'b0; a1 = ~av; b1 = ~bv;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (done1) begin
                    ndone++;
                    if (first_done < 0) begin first_done = k; at_done = {eb ^ 1'b0 ? borrow1 : borrow1, diff1}; end
                end
            end
            checks++;
            if (first_done != 2 || ndone != 1 || at_done !== {eb, ed}) begin
                errors++;
                $display("FAIL w1_%0d%0d: done at %0d count %0d borrow/diff=%b/%b, required 2 1 %b/%b",
                         av, bv, first_done, ndone, at_done[1], at_done[0], eb, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        int         issued = 0;
        int         seen = 0;
        int         last_t = -1;
        int         bad_res = 0;
        int         bad_gap = 0;
        int         t = 0;
        logic [8:0] exp;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        qa.push_back(a8); qb.push_back(b8); issued = 1;
        while (seen < 1000 && t < 11000) begin
            @(negedge clk);
            t++;
            if (done8) begin
                exp = ref8(qa.pop_front(), qb.pop_front());
                if ({borrow8, diff8} !== exp) begin
                    bad_res++;
                    if (bad_res <= 5)
                        $display("FAIL b2b_result op %0d: borrow/diff=%b/%h, required %b/%h", seen, borrow8, diff8, exp[8], exp[7:0]);
                end
                if (last_t >= 0 && t - last_t != 10) bad_gap++;
                last_t = t;
                seen++;
                if (issued < 1000) begin
                    a8 = 8'($urandom); b8 = 8'($urandom);
                    qa.push_back(a8); qb.push_back(b8); issued++;
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        checks++;
        if (seen != 1000) begin
            errors++;
            $display("FAIL b2b_count: %0d results, required 1000", seen);
        end
        checks++;
        if (bad_res != 0) begin
            errors++;
            $display("FAIL b2b_results: %0d wrong results, required 0", bad_res);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL b2b_spacing: %0d gaps not 10 cycles, required 0", bad_gap);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid_run();
        test_width1();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
